// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - RV32I write-back stage and 32x32 register file
// Optional same-cycle write-to-read forwarding: define WB_BYPASS_EN.
module regfile_wb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [XLEN-1:0]  reg_data1,
  output logic [XLEN-1:0]  reg_data2,
  input  logic             wb_valid,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [1:0]       wb_sel,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  imm,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             misalign_q, misalign_d;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;
  logic            ld_bad;
  logic [XLEN-1:0] wb_value;
  logic            load_mis;
  logic            commit;
  logic            retire;

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_lo)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_val  = mem_rdata;
    ld_bad  = 1'b0;
    // Unsupported load encodings are dropped the same way as misaligned ones.
    case (funct3)
      3'b000: ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001: begin
        ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_bad = addr_lo[0];
      end
      3'b010: ld_bad = (addr_lo != 2'b00);
      3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101: begin
        ld_val = {{(XLEN-16){1'b0}}, ld_half};
        ld_bad = addr_lo[0];
      end
      default: ld_bad = 1'b1;
    endcase
  end

  always_comb begin
    case (wb_sel)
      SEL_ALU:  wb_value = alu_result;
      SEL_LOAD: wb_value = ld_val;
      SEL_LINK: wb_value = pc_plus4;
      default:  wb_value = imm;
    endcase
  end

  assign load_mis = (wb_sel == SEL_LOAD) && ld_bad;
  assign commit   = wb_valid && wb_we && (wb_rd != 5'd0) && !load_mis;
  assign retire   = wb_valid && !load_mis;

  assign instret_d  = retire ? instret_q + CNT_W'(1) : instret_q;
  assign misalign_d = wb_valid && load_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      instret_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (commit) regs_q[wb_rd] <= wb_value;
      instret_q  <= instret_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign reg_data1 = (rs1 == 5'd0) ? '0 :
                     (commit && !rst && rs1 == wb_rd) ? wb_value : regs_q[rs1];
  assign reg_data2 = (rs2 == 5'd0) ? '0 :
                     (commit && !rst && rs2 == wb_rd) ? wb_value : regs_q[rs2];
`else
  assign reg_data1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign reg_data2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];
`endif

  assign misalign_err = misalign_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - randomized model-checked bench for regfile_wb
module tb_regfile_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, wb_rd;
  logic [31:0] reg_data1, reg_data2;
  logic        wb_valid, wb_we;
  logic [1:0]  wb_sel, addr_lo;
  logic [31:0] alu_result, mem_rdata, pc_plus4, imm;
  logic [2:0]  funct3;
  logic        misalign_err;
  logic [31:0] instret;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_instret;
  logic        m_mis;

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .reg_data1(reg_data1), .reg_data2(reg_data2),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_sel(wb_sel),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .addr_lo(addr_lo),
    .funct3(funct3), .pc_plus4(pc_plus4), .imm(imm),
    .misalign_err(misalign_err), .instret(instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes from funct3; 0 marks an unsupported encoding.
  function automatic int m_size();
    case (funct3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_misaligned();
    int sz = m_size();
    if (wb_sel != 2'b01) return 1'b0;
    if (sz == 0) return 1'b1;
    return (int'(addr_lo) % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load();
    int sz = m_size();
    int bits;
    logic [63:0] v, mask;
    if (sz == 0) sz = 4;
    bits = sz * 8;
    mask = (64'd1 << bits) - 64'd1;
    v = ({32'd0, mem_rdata} >> (int'(addr_lo) * 8)) & mask;
    if (!funct3[2] && v[bits-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wbval();
    case (wb_sel)
      2'b00:   return alu_result;
      2'b01:   return m_load();
      2'b10:   return pc_plus4;
      default: return imm;
    endcase
  endfunction

  function automatic bit m_commit();
    return !rst && wb_valid && wb_we && wb_rd != 0 && !m_misaligned();
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (m_commit() && a == wb_rd) return m_wbval();
`endif
    return m_regs[a];
  endfunction

  task automatic m_clear();
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_instret = 32'd0;
    m_mis = 1'b0;
  endtask

  task automatic m_edge();
    bit mis;
    if (rst) begin
      m_clear();
      return;
    end
    mis = m_misaligned();
    if (m_commit()) m_regs[wb_rd] = m_wbval();
    if (wb_valid && !mis) m_instret = m_instret + 32'd1;
    m_mis = wb_valid && mis;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle(input logic [4:0] a, input logic [4:0] b);
    wb_valid = 1'b0; wb_we = 1'b0; rs1 = a; rs2 = b;
  endtask

  task automatic instr(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val,
                       input logic [2:0] f3, input logic [1:0] alo);
    wb_valid = 1'b1; wb_we = 1'b1; wb_sel = sel; wb_rd = rd;
    alu_result = val; mem_rdata = val; pc_plus4 = val; imm = val;
    funct3 = f3; addr_lo = alo;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reg_data1", reg_data1, m_read(rs1));
      chk("reg_data2", reg_data2, m_read(rs2));
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      chk("instret", instret, m_instret);
    end
  end

  initial begin
    rst = 1'b1; rs1 = 5'd1; rs2 = 5'd2; wb_valid = 1'b0; wb_we = 1'b0; wb_rd = 5'd0;
    wb_sel = 2'b00; alu_result = '0; mem_rdata = '0; addr_lo = '0; funct3 = '0;
    pc_plus4 = '0; imm = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd1", reg_data1, 32'd0);
    chk("reset_rd2", reg_data2, 32'd0);
    chk("reset_instret", instret, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    instr(2'b00, 5'd1, 32'h1111_1111, 3'b010, 2'd0); step();
    instr(2'b00, 5'd2, 32'h2222_2222, 3'b010, 2'd0); step();
    idle(5'd1, 5'd2); #1;
    chk("alu_x1", reg_data1, 32'h1111_1111);
    chk("alu_x2", reg_data2, 32'h2222_2222);
    chk("instret_2", instret, 32'd2);

    instr(2'b01, 5'd3, 32'h0000_80FF, 3'b000, 2'd1); step();
    idle(5'd3, 5'd0); #1;
    chk("lb_x3", reg_data1, 32'hFFFF_FF80);
    instr(2'b01, 5'd3, 32'h0000_80FF, 3'b100, 2'd1); step();
    idle(5'd3, 5'd0); #1;
    chk("lbu_x3", reg_data1, 32'h0000_0080);

    instr(2'b01, 5'd4, 32'h8001_0000, 3'b001, 2'd2); step();
    idle(5'd4, 5'd0); #1;
    chk("lh_x4", reg_data1, 32'hFFFF_8001);
    instr(2'b01, 5'd4, 32'h8001_0000, 3'b010, 2'd2); step();
    idle(5'd4, 5'd0); #1;
    chk("lw_mis_x4", reg_data1, 32'hFFFF_8001);
    chk("lw_mis_err", {31'd0, misalign_err}, 32'd1);
    chk("lw_mis_instret", instret, 32'd5);
    step();
    chk("mis_err_clear", {31'd0, misalign_err}, 32'd0);

    instr(2'b00, 5'd0, 32'hDEAD_BEEF, 3'b010, 2'd0); step();
    idle(5'd0, 5'd0); #1;
    chk("x0_zero", reg_data1, 32'd0);
    chk("x0_instret", instret, 32'd6);
    instr(2'b10, 5'd5, 32'h0000_0104, 3'b010, 2'd0); step();
    idle(5'd0, 5'd5); #1;
    chk("link_x5", reg_data2, 32'h0000_0104);

    instr(2'b00, 5'd6, 32'h1234_5678, 3'b010, 2'd0); step();
    instr(2'b00, 5'd6, 32'hA5A5_A5A5, 3'b010, 2'd0);
    rs1 = 5'd6; #1;
`ifdef WB_BYPASS_EN
    chk("bypass_same", reg_data1, 32'hA5A5_A5A5);
`else
    chk("bypass_same", reg_data1, 32'h1234_5678);
`endif
    step();
    idle(5'd6, 5'd0); #1;
    chk("bypass_next", reg_data1, 32'hA5A5_A5A5);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; m_clear(); #2; rst = 1'b0;
      end
      wb_valid   = ($urandom_range(0, 9) < 8);
      wb_we      = $urandom_range(0, 1);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_sel     = 2'($urandom_range(0, 3));
      alu_result = $urandom; mem_rdata = $urandom; pc_plus4 = $urandom; imm = $urandom;
      addr_lo    = 2'($urandom_range(0, 3));
      funct3     = 3'($urandom_range(0, 7));
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom_range(0, 7));
      step();
    end

    idle(5'd1, 5'd2);
    instr(2'b00, 5'd1, 32'h5555_AAAA, 3'b010, 2'd0); step();
    #2; rst = 1'b1; m_clear(); #1;
    chk("async_rst_rd1", reg_data1, 32'd0);
    chk("async_rst_rd2", reg_data2, 32'd0);
    chk("async_rst_instret", instret, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
